tlb_translate_unit: RTL and testbench

TLB_TRANSLATE_UNIT -- requirements
Module: tlb_translate_unit

---
 rtl/tlb_translate_unit.sv | 142 ++++++++++++++
 tb/tb_tlb_translate_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_translate_unit.sv
// Four-entry fully associative TLB with a blocking page-table walker.
// Misses stall the lookup stage, walk memory for a PTE, fill a round-robin victim and replay.
module tlb_translate_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        lookup_valid,
    input  logic [15:0] lookup_vaddr,
    input  logic [15:0] ptbr,
    input  logic        flush,
    output logic        stall,
    output logic        result_valid,
    output logic [15:0] result_paddr,
    output logic        fault,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_data
);
    localparam int unsigned ENTRIES = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned VPN_W   = 8;
    localparam int unsigned PPN_W   = 8;
    localparam int unsigned ADDR_W  = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WALK  = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [ENTRIES-1:0] tlb_valid;
    logic [VPN_W-1:0]   tlb_vpn [ENTRIES];
    logic [PPN_W-1:0]   tlb_ppn [ENTRIES];
    logic [IDX_W-1:0]   victim;
    logic [VPN_W-1:0]   walk_vpn;
    logic [PPN_W-1:0]   walk_ppn;

    logic [VPN_W-1:0]   lookup_vpn;
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;

    assign lookup_vpn = lookup_vaddr[15:8];

    // Associative match; scanning downward leaves the lowest matching index.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (tlb_valid[i] && (tlb_vpn[i] == lookup_vpn)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (lookup_valid && !hit) begin
                    stall     = 1'b1;
                    state_nxt = ST_WALK;
                end
            end
            ST_WALK: begin
                stall = 1'b1;
                if (mem_ack) state_nxt = mem_data[15] ? ST_FILL : ST_FAULT;
            end
            ST_FILL: begin
                stall     = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_FAULT: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: result/walk registers and TLB array updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            tlb_valid    <= '0;
            victim       <= '0;
            walk_vpn     <= '0;
            walk_ppn     <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            result_valid <= 1'b0;
            result_paddr <= '0;
            fault        <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            fault        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (lookup_valid) begin
                        if (hit) begin
                            result_valid <= 1'b1;
                            result_paddr <= {tlb_ppn[hit_idx], lookup_vaddr[7:0]};
                        end else begin
                            walk_vpn <= lookup_vpn;
                            mem_req  <= 1'b1;
                            mem_addr <= ADDR_W'(ptbr + {8'h00, lookup_vpn});
                        end
                    end
                end
                ST_WALK: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (mem_data[15]) begin
                            walk_ppn <= mem_data[7:0];
                        end else begin
                            result_valid <= 1'b1;
                            fault        <= 1'b1;
                            result_paddr <= '0;
                        end
                    end
                end
                ST_FILL: begin
                    if (!flush) begin
                        tlb_valid[victim] <= 1'b1;
                        tlb_vpn[victim]   <= walk_vpn;
                        tlb_ppn[victim]   <= walk_ppn;
                        victim            <= IDX_W'(victim + 1'b1);
                    end
                end
                default: ;
            endcase
            // Flush overrides any fill in the same cycle.
            if (flush) begin
                tlb_valid <= '0;
                victim    <= '0;
            end
        end
    end
endmodule

// File: tb/tb_tlb_translate_unit.sv
// Randomized bench for tlb_translate_unit against a transaction-level TLB model.
module tb_tlb_translate_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        lookup_valid;
    logic [15:0] lookup_vaddr;
    logic [15:0] ptbr;
    logic        flush;
    logic        stall;
    logic        result_valid;
    logic [15:0] result_paddr;
    logic        fault;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;

    always #5 clk = ~clk;

    tlb_translate_unit dut (
        .clk          (clk),
        .reset        (reset),
        .lookup_valid (lookup_valid),
        .lookup_vaddr (lookup_vaddr),
        .ptbr         (ptbr),
        .flush        (flush),
        .stall        (stall),
        .result_valid (result_valid),
        .result_paddr (result_paddr),
        .fault        (fault),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: translation cache contents, replacement pointer, page table.
    bit          m_valid [4];
    logic [7:0]  m_vpn   [4];
    logic [7:0]  m_ppn   [4];
    int          m_ptr;
    logic [15:0] pt      [256];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int m_find(input logic [7:0] vpn);
        for (int i = 0; i < 4; i++)
            if (m_valid[i] && m_vpn[i] == vpn) return i;
        return -1;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        m_ptr = 0;
    endfunction

    // One lookup from presentation until its result; caller is positioned just after a rising edge.
    task automatic lookup(input logic [15:0] va, input logic [15:0] base, input int lat, input bit flush_fill);
        logic [7:0] vpn;
        int         idx;
        bit         done;
        vpn  = va[15:8];
        done = 1'b0;
        for (int attempt = 0; attempt < 3 && !done; attempt++) begin
            lookup_valid = 1'b1;
            lookup_vaddr = va;
            ptbr         = base;
            idx          = m_find(vpn);
            @(negedge clk);
            check_eq("stall_on_request", 32'(stall), 32'(idx < 0));
            if (idx >= 0) begin
                step();
                lookup_valid = 1'b0;
                mem_ack      = 1'($urandom);
                @(negedge clk);
                check_eq("hit_valid", 32'(result_valid), 32'd1);
                check_eq("hit_fault", 32'(fault), 32'd0);
                check_eq("hit_paddr", 32'(result_paddr), 32'({m_ppn[idx], va[7:0]}));
                check_eq("hit_no_memreq", 32'(mem_req), 32'd0);
                step();
                mem_ack = 1'b0;
                @(negedge clk);
                check_eq("idle_no_result", 32'(result_valid), 32'd0);
                step();
                done = 1'b1;
            end else begin
                step();
                @(negedge clk);
                check_eq("walk_req", 32'(mem_req), 32'd1);
                check_eq("walk_addr", 32'(mem_addr), 32'(16'(base + {8'h00, vpn})));
                check_eq("walk_stall", 32'(stall), 32'd1);
                for (int k = 0; k < lat; k++) begin
                    step();
                    ptbr = 16'($urandom);
                    @(negedge clk);
                    check_eq("walk_addr_held", 32'(mem_addr), 32'(16'(base + {8'h00, vpn})));
                    check_eq("walk_req_held", 32'(mem_req), 32'd1);
                end
                step();
                mem_ack  = 1'b1;
                mem_data = pt[vpn];
                step();
                mem_ack  = 1'($urandom);
                mem_data = 16'($urandom);
                if (pt[vpn][15]) begin
                    flush = flush_fill;
                    @(negedge clk);
                    check_eq("fill_stall", 32'(stall), 32'd1);
                    check_eq("fill_req_drop", 32'(mem_req), 32'd0);
                    check_eq("fill_no_result", 32'(result_valid), 32'd0);
                    if (flush_fill) begin
                        m_clear();
                    end else begin
                        m_valid[m_ptr] = 1'b1;
                        m_vpn[m_ptr]   = vpn;
                        m_ppn[m_ptr]   = pt[vpn][7:0];
                        m_ptr          = (m_ptr + 1) % 4;
                    end
                    step();
                    flush      = 1'b0;
                    mem_ack    = 1'b0;
                    flush_fill = 1'b0;
                end else begin
                    @(negedge clk);
                    check_eq("fault_valid", 32'(result_valid), 32'd1);
                    check_eq("fault_flag", 32'(fault), 32'd1);
                    check_eq("fault_paddr", 32'(result_paddr), 32'd0);
                    check_eq("fault_stall", 32'(stall), 32'd0);
                    step();
                    lookup_valid = 1'b0;
                    mem_ack      = 1'b0;
                    done         = 1'b1;
                end
            end
        end
        check_eq("lookup_completed", 32'(done), 32'd1);
        lookup_valid = 1'b0;
    endtask

    task automatic flush_idle();
        flush = 1'b1;
        @(negedge clk);
        check_eq("flush_no_result", 32'(result_valid), 32'd0);
        step();
        flush = 1'b0;
        m_clear();
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check_eq({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check_eq({tag, "_result_valid"}, 32'(result_valid), 32'd0);
        check_eq({tag, "_fault"}, 32'(fault), 32'd0);
        check_eq({tag, "_paddr"}, 32'(result_paddr), 32'd0);
        check_eq({tag, "_stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        lookup_valid = 1'b0;
        lookup_vaddr = '0;
        ptbr         = '0;
        flush        = 1'b0;
        mem_ack      = 1'b0;
        mem_data     = '0;
        m_clear();
        for (int i = 0; i < 256; i++) pt[i] = 16'($urandom);
        step();
        step();
        check_reset_outputs("reset");
        step();
        reset = 1'b0;

        // Cold miss, then hit on the same page.
        pt[8'h34] = 16'h80AB;
        lookup(16'h3456, 16'h1000, 2, 1'b0);
        lookup(16'h34FF, 16'h1000, 0, 1'b0);

        // Invalid PTE produces a fault and leaves the cache untouched.
        pt[8'h56] = 16'h00AB;
        lookup(16'h5612, 16'h1000, 1, 1'b0);
        lookup(16'h5634, 16'h1000, 0, 1'b0);

        // Five fills through four entries: VPN 01 evicted, pointer wraps.
        flush_idle();
        for (int v = 1; v <= 5; v++) begin
            pt[v] = 16'h8000 | 16'(v * 16'h11);
            lookup({8'(v), 8'h20}, 16'h0200, v % 3, 1'b0);
        end
        for (int v = 2; v <= 5; v++) lookup({8'(v), 8'h40}, 16'h0200, 0, 1'b0);
        lookup(16'h0160, 16'h0200, 1, 1'b0);

        // Flush coincident with fill forces a re-walk; idle flush clears all.
        pt[8'h77] = 16'h80C3;
        lookup(16'h7701, 16'hFFF0, 1, 1'b1);
        flush_idle();
        lookup(16'h0233, 16'h0200, 0, 1'b0);

        // Reset mid-walk abandons the walk; a late ack is ignored.
        pt[8'h99] = 16'h8011;
        lookup_valid = 1'b1;
        lookup_vaddr = 16'h9900;
        ptbr         = 16'h0300;
        step();
        @(negedge clk);
        check_eq("prereset_walk_req", 32'(mem_req), 32'd1);
        step();
        reset        = 1'b1;
        lookup_valid = 1'b0;
        step();
        reset   = 1'b0;
        mem_ack = 1'b1;
        mem_data = 16'h8011;
        check_reset_outputs("midwalk_reset");
        step();
        mem_ack = 1'b0;
        check_reset_outputs("late_ack");
        m_clear();
        step();

        // Randomized traffic over a small VPN pool so hits, misses and evictions mix.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                flush_idle();
            end else begin
                lookup({8'($urandom_range(0, 9)), 8'($urandom)}, 16'($urandom),
                       int'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
